systolic_deskew: RTL and testbench

- Output-side counterpart of the input skew delay lines: collects the diagonally skewed results leaving the bottom or right edge of the systolic array and realigns them into full rows.
- Lane i arrives i cycles after lane 0. The block delays each lane to line them up, checks alignment, buffers rows in a small FIFO with a valid/ready handshake, and counts rows per output tile.
- Sits between the array edge and the writeback/DMA path. The array cannot stall, so backpressure is absorbed by the FIFO and overflow is flagged.

---
 rtl/systolic_pkg.sv | 23 ++
 rtl/deskew_fifo.sv | 61 ++++++
 rtl/systolic_deskew.sv | 154 +++++++++++++++
 tb/tb_systolic_deskew.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared constants, types and helpers for the systolic output deskew block.
package systolic_pkg;

   localparam int DEFAULT_WIDTH = 32;
   localparam int DEFAULT_LANES = 4;

   typedef logic [DEFAULT_LANES-1:0][DEFAULT_WIDTH-1:0] aligned_row_t;

   typedef enum logic {
      TILE_IDLE   = 1'b0,
      TILE_ACTIVE = 1'b1
   } tile_state_t;

   // Low bit of lane `lane` inside a flattened LANES*WIDTH bus.
   function automatic int lane_lsb(input int lane, input int width);
      return lane * width;
   endfunction

   function automatic int ptr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/deskew_fifo.sv
// Synchronous FIFO holding aligned rows; push while full is accepted only
// when a pop frees the head slot on the same edge.
module deskew_fifo
   import systolic_pkg::*;
#(
   parameter int WIDTH = 128,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int PW = ptr_width(DEPTH);
   localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q;
   logic [PW-1:0]    rd_ptr_q;
   logic [PW:0]      count_q;
   logic             wr_en;
   logic             rd_en;

   assign full_o  = (count_q == FULL_CNT);
   assign empty_o = (count_q == '0);
   assign rd_en   = pop_i & ~empty_o;
   assign wr_en   = push_i & (~full_o | rd_en);
   assign rdata_o = mem_q[rd_ptr_q];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (rd_en) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         case ({wr_en, rd_en})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/systolic_deskew.sv
// Realigns diagonally skewed array-edge lanes into rows, buffers them and counts
// rows per tile. Define SYSTOLIC_DESKEW_STATS_EN to add drop_count/row_total.
module systolic_deskew
   import systolic_pkg::*;
#(
   parameter int WIDTH      = DEFAULT_WIDTH,
   parameter int LANES      = DEFAULT_LANES,
   parameter int ROWS       = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [LANES*WIDTH-1:0] in_data,
   input  logic [LANES-1:0]       in_valid,
   output logic [LANES*WIDTH-1:0] out_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   done_pulse,
   output logic                   overflow_err,
   output logic                   misalign_err
`ifdef SYSTOLIC_DESKEW_STATS_EN
   ,
   output logic [15:0]            drop_count,
   output logic [31:0]            row_total
`endif
);

   localparam int CW = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam logic [CW-1:0] LAST_ROW = CW'(ROWS - 1);

   logic [LANES*WIDTH-1:0] al_data;
   logic [LANES-1:0]       al_valid;

   // Lane gi arrives gi cycles late, so it waits LANES-1-gi stages.
   for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      localparam int STAGES = LANES - 1 - gi;
      localparam int LSB    = lane_lsb(gi, WIDTH);
      if (STAGES == 0) begin : g_direct
         assign al_data[LSB +: WIDTH] = in_data[LSB +: WIDTH];
         assign al_valid[gi]          = in_valid[gi];
      end else begin : g_delay
         logic [WIDTH-1:0]  data_q [STAGES];
         logic [STAGES-1:0] valid_q;
         always_ff @(posedge clk) begin
            data_q[0] <= in_data[LSB +: WIDTH];
            for (int s = 1; s < STAGES; s++) begin
               data_q[s] <= data_q[s-1];
            end
            if (reset) begin
               valid_q <= '0;
            end else begin
               valid_q[0] <= in_valid[gi];
               for (int s = 1; s < STAGES; s++) begin
                  valid_q[s] <= valid_q[s-1];
               end
            end
         end
         assign al_data[LSB +: WIDTH] = data_q[STAGES-1];
         assign al_valid[gi]          = valid_q[STAGES-1];
      end
   end

   logic push_req;
   logic mis_drop;
   logic ovf_drop;
   logic pop;
   logic fifo_full;
   logic fifo_empty;

   assign push_req  = &al_valid;
   assign mis_drop  = (|al_valid) & ~push_req;
   assign out_valid = ~fifo_empty;
   assign pop       = out_valid & out_ready;
   assign ovf_drop  = push_req & fifo_full & ~pop;

   deskew_fifo #(
      .WIDTH (LANES*WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (push_req),
      .wdata_i (al_data),
      .pop_i   (pop),
      .rdata_o (out_data),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   logic [CW-1:0] row_cnt_q;
   tile_state_t   tile_q;
   logic          done_q;
   logic          ovf_q;
   logic          mis_q;
   logic          last_row;

   assign last_row = ((tile_q == TILE_ACTIVE) || (ROWS == 1)) && (row_cnt_q == LAST_ROW);

   always_ff @(posedge clk) begin
      if (reset) begin
         row_cnt_q <= '0;
         tile_q    <= TILE_IDLE;
         done_q    <= 1'b0;
         ovf_q     <= 1'b0;
         mis_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (pop) begin
            if (last_row) begin
               row_cnt_q <= '0;
               tile_q    <= TILE_IDLE;
               done_q    <= 1'b1;
            end else begin
               row_cnt_q <= row_cnt_q + 1'b1;
               tile_q    <= TILE_ACTIVE;
            end
         end
         if (ovf_drop) begin
            ovf_q <= 1'b1;
         end
         if (mis_drop) begin
            mis_q <= 1'b1;
         end
      end
   end

   assign done_pulse   = done_q;
   assign overflow_err = ovf_q;
   assign misalign_err = mis_q;

`ifdef SYSTOLIC_DESKEW_STATS_EN
   logic [15:0] drop_cnt_q;
   logic [31:0] row_total_q;

   // Overflow and misalign drops are mutually exclusive within a cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         drop_cnt_q  <= '0;
         row_total_q <= '0;
      end else begin
         if ((ovf_drop || mis_drop) && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_q <= drop_cnt_q + 1'b1;
         end
         if (pop) begin
            row_total_q <= row_total_q + 1'b1;
         end
      end
   end

   assign drop_count = drop_cnt_q;
   assign row_total  = row_total_q;
`endif

endmodule

// File: tb/tb_systolic_deskew.sv
// Self-checking bench for systolic_deskew: directed vector table, hand-written
// corner sequences and a randomized run against a row-level reference model.
module tb_systolic_deskew;

   localparam int WIDTH = 32;
   localparam int LANES = 4;
   localparam int ROWS  = 4;
   localparam int DEPTH = 4;
   localparam int RW    = LANES * WIDTH;
   localparam int MAXC  = 4096;

   logic             clk = 1'b0;
   logic             reset;
   logic [RW-1:0]    in_data;
   logic [LANES-1:0] in_valid;
   logic [RW-1:0]    out_data;
   logic             out_valid;
   logic             out_ready;
   logic             done_pulse;
   logic             overflow_err;
   logic             misalign_err;
`ifdef SYSTOLIC_DESKEW_STATS_EN
   logic [15:0]      drop_count;
   logic [31:0]      row_total;
`endif

   always #5 clk = ~clk;

   systolic_deskew #(
      .WIDTH      (WIDTH),
      .LANES      (LANES),
      .ROWS       (ROWS),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .out_data     (out_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .done_pulse   (done_pulse),
      .overflow_err (overflow_err),
      .misalign_err (misalign_err)
`ifdef SYSTOLIC_DESKEW_STATS_EN
      ,
      .drop_count   (drop_count),
      .row_total    (row_total)
`endif
   );

   typedef struct {
      logic             inj;
      logic [LANES-1:0] mask;
      int               base;
      logic             rdy;
      logic             ev;
      int               ed;
      logic             edone;
      logic             eovf;
      logic             emis;
   } tvec_t;

   tvec_t tab [25];
   tvec_t tab_exp;
   logic  tab_chk = 1'b0;
   logic  chk_en  = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: every injected row is remembered by cycle; the row
   // injected at cycle t is judged by its lane-valid mask at edge t+LANES-1.
   logic [LANES-1:0] hist_mask [MAXC];
   logic [RW-1:0]    hist_row  [MAXC];
   int               cyc        = 0;
   int               valid_from = 0;
   logic [RW-1:0]    q [$];
   int               m_tile  = 0;
   logic             m_done  = 1'b0;
   logic             m_ovf   = 1'b0;
   logic             m_mis   = 1'b0;
   int               m_drops = 0;
   int unsigned      m_total = 0;

   logic          obs_valid, obs_done, obs_ovf, obs_mis;
   logic [RW-1:0] obs_data;
   int            done_seen = 0;
   int            dut_pops  = 0;
   logic          lat [14];
   logic          dn  [14];

   task automatic chk1(input string nm, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b want %b (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic chkv(input string nm, input logic [RW-1:0] act, input logic [RW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic logic [RW-1:0] mkrow(input int base);
      logic [RW-1:0] r;
      for (int i = 0; i < LANES; i++) begin
         r[i*WIDTH +: WIDTH] = WIDTH'(base + i);
      end
      return r;
   endfunction

   // One clock: check outputs at negedge, drive the skewed lanes, advance the model.
   task automatic step(input logic [LANES-1:0] mask, input logic [RW-1:0] row,
                       input logic rdy, input logic rst);
      logic [LANES-1:0] amask;
      logic             pop;
      logic             nd;
      int               src;
      @(negedge clk);
      obs_valid = out_valid;
      obs_data  = out_data;
      obs_done  = done_pulse;
      obs_ovf   = overflow_err;
      obs_mis   = misalign_err;
      if (chk_en) begin
         chk1("out_valid", out_valid, q.size() > 0);
         if (q.size() > 0 && out_valid) chkv("out_data", out_data, q[0]);
         chk1("done_pulse", done_pulse, m_done);
         chk1("overflow_err", overflow_err, m_ovf);
         chk1("misalign_err", misalign_err, m_mis);
`ifdef SYSTOLIC_DESKEW_STATS_EN
         chkv("drop_count", RW'(drop_count), RW'(m_drops));
         chkv("row_total", RW'(row_total), RW'(m_total));
`endif
      end
      if (tab_chk) begin
         chk1("tab_valid", out_valid, tab_exp.ev);
         if (tab_exp.ev) chkv("tab_lane0", RW'(out_data[WIDTH-1:0]), RW'(tab_exp.ed));
         chk1("tab_done", done_pulse, tab_exp.edone);
         chk1("tab_ovf", overflow_err, tab_exp.eovf);
         chk1("tab_mis", misalign_err, tab_exp.emis);
      end
      if (done_pulse) done_seen++;
      if (out_valid && rdy && !rst) begin
         dut_pops++;
         $display("cycle %0d pop row %h", cyc, out_data);
      end

      hist_mask[cyc] = mask;
      hist_row[cyc]  = row;
      for (int i = 0; i < LANES; i++) begin
         src = cyc - i;
         if (src >= valid_from) begin
            in_valid[i]             = hist_mask[src][i];
            in_data[i*WIDTH +: WIDTH] = hist_row[src][i*WIDTH +: WIDTH];
         end else begin
            in_valid[i]             = 1'b0;
            in_data[i*WIDTH +: WIDTH] = '0;
         end
      end
      out_ready = rdy;
      reset     = rst;

      if (rst) begin
         q.delete();
         m_tile     = 0;
         m_done     = 1'b0;
         m_ovf      = 1'b0;
         m_mis      = 1'b0;
         m_drops    = 0;
         m_total    = 0;
         valid_from = cyc + 1;
      end else begin
         pop = (q.size() > 0) && rdy;
         src = cyc - (LANES - 1);
         amask = (src >= valid_from) ? hist_mask[src] : '0;
         nd = 1'b0;
         if (pop) begin
            void'(q.pop_front());
            m_total++;
            m_tile++;
            if (m_tile == ROWS) begin
               m_tile = 0;
               nd     = 1'b1;
            end
         end
         if (&amask) begin
            if (q.size() < DEPTH) begin
               q.push_back(hist_row[src]);
            end else begin
               m_ovf = 1'b1;
               if (m_drops < 65535) m_drops++;
            end
         end else if (amask != '0) begin
            m_mis = 1'b1;
            if (m_drops < 65535) m_drops++;
         end
         m_done = nd;
      end
      cyc++;
   endtask

   initial begin
      //          inj  mask  base rdy   ev  ed  done ovf  mis
      tab = '{
         '{1'b1, 4'hF,  1, 1'b1, 1'b0,  0, 1'b0, 1'b0, 1'b0},
         '{1'b1, 4'hF,  5, 1'b1, 1'b0,  0, 1'b0, 1'b0, 1'b0},
         '{1'b0, 4'h0,  0, 1'b1, 1'b0,  0, 1'b0, 1'b0, 1'b0},
         '{1'b0, 4'h0,  0, 1'b1, 1'b0,  0, 1'b0, 1'b0, 1'b0},
         '{1'b0, 4'h0,  0, 1'b1, 1'b1,  1, 1'b0, 1'b0, 1'b0},
         '{1'b0, 4'h0,  0, 1'b1, 1'b1,  5, 1'b0, 1'b0, 1'b0},
         '{1'b1, 4'hF,  9, 1'b0, 1'b0,  0, 1'b0, 1'b0, 1'b0},
         '{1'b1, 4'hF, 13, 1'b0, 1'b0,  0, 1'b0, 1'b0, 1'b0},
         '{1'b1, 4'hF, 17, 1'b0, 1'b0,  0, 1'b0, 1'b0, 1'b0},
         '{1'b1, 4'hF, 21, 1'b0, 1'b0,  0, 1'b0, 1'b0, 1'b0},
         '{1'b1, 4'hF, 25, 1'b0, 1'b1,  9, 1'b0, 1'b0, 1'b0},
         '{1'b0, 4'h0,  0, 1'b0, 1'b1,  9, 1'b0, 1'b0, 1'b0},
         '{1'b0, 4'h0,  0, 1'b0, 1'b1,  9, 1'b0, 1'b0, 1'b0},
         '{1'b0, 4'h0,  0, 1'b0, 1'b1,  9, 1'b0, 1'b0, 1'b0},
         '{1'b0, 4'h0,  0, 1'b1, 1'b1,  9, 1'b0, 1'b1, 1'b0},
         '{1'b0, 4'h0,  0, 1'b1, 1'b1, 13, 1'b0, 1'b1, 1'b0},
         '{1'b0, 4'h0,  0, 1'b1, 1'b1, 17, 1'b1, 1'b1, 1'b0},
         '{1'b0, 4'h0,  0, 1'b1, 1'b1, 21, 1'b0, 1'b1, 1'b0},
         '{1'b1, 4'hB, 29, 1'b1, 1'b0,  0, 1'b0, 1'b1, 1'b0},
         '{1'b1, 4'hF, 33, 1'b1, 1'b0,  0, 1'b0, 1'b1, 1'b0},
         '{1'b0, 4'h0,  0, 1'b1, 1'b0,  0, 1'b0, 1'b1, 1'b0},
         '{1'b0, 4'h0,  0, 1'b1, 1'b0,  0, 1'b0, 1'b1, 1'b0},
         '{1'b0, 4'h0,  0, 1'b1, 1'b0,  0, 1'b0, 1'b1, 1'b1},
         '{1'b0, 4'h0,  0, 1'b1, 1'b1, 33, 1'b0, 1'b1, 1'b1},
         '{1'b0, 4'h0,  0, 1'b1, 1'b0,  0, 1'b0, 1'b1, 1'b1}
      };

      reset     = 1'b1;
      in_data   = '0;
      in_valid  = '0;
      out_ready = 1'b0;
      step('0, '0, 1'b0, 1'b1);
      step('0, '0, 1'b0, 1'b1);
      chk_en = 1'b1;

      // Directed table: aligned rows, overflow with drain, misaligned row.
      for (int k = 0; k < 25; k++) begin
         tab_exp = tab[k];
         tab_chk = 1'b1;
         step(tab[k].inj ? tab[k].mask : 4'h0, mkrow(tab[k].base), tab[k].rdy, 1'b0);
      end
      tab_chk = 1'b0;

      // Full FIFO with simultaneous push and pop: nothing may be dropped.
      step('0, '0, 1'b0, 1'b1);
      dut_pops = 0;
      for (int k = 0; k < 10; k++) step(4'hF, mkrow(200 + 4*k), k >= 7, 1'b0);
      for (int k = 0; k < 8; k++) step('0, '0, 1'b1, 1'b0);
      chk1("fullpp_no_overflow", obs_ovf, 1'b0);
      chkv("fullpp_pop_count", RW'(dut_pops), RW'(10));

      // Reset mid-tile with rows buffered and skewed samples in flight.
      step('0, '0, 1'b0, 1'b1);
      step(4'h1, mkrow(290), 1'b1, 1'b0);
      step(4'hF, mkrow(300), 1'b1, 1'b0);
      step(4'hF, mkrow(304), 1'b1, 1'b0);
      for (int k = 0; k < 4; k++) step('0, '0, 1'b1, 1'b0);
      for (int k = 0; k < 4; k++) step(4'hF, mkrow(400 + 4*k), 1'b0, 1'b0);
      step('0, '0, 1'b0, 1'b0);
      chk1("pre_reset_mis", obs_mis, 1'b1);
      chk1("pre_reset_buffered", obs_valid, 1'b1);
      step('0, '0, 1'b0, 1'b1);
      for (int k = 0; k < 14; k++) begin
         if (k < 8) step(4'hF, mkrow(500 + 4*k), 1'b1, 1'b0);
         else       step('0, '0, 1'b1, 1'b0);
         lat[k] = obs_valid;
         dn[k]  = obs_done;
         if (k == 0) begin
            chk1("post_reset_valid", obs_valid, 1'b0);
            chk1("post_reset_mis", obs_mis, 1'b0);
            chk1("post_reset_done", obs_done, 1'b0);
         end
      end
      chk1("latency_not_3", lat[3], 1'b0);
      chk1("latency_4", lat[4], 1'b1);
      chk1("done_after_4th", dn[8], 1'b1);
      chk1("done_after_8th", dn[12], 1'b1);
      chk1("no_done_7th", dn[11], 1'b0);

      // Randomized traffic against the reference model.
      for (int k = 0; k < 600; k++) begin
         logic [LANES-1:0] m;
         int r;
         r = int'($urandom_range(0, 39));
         if (r == 0)     m = LANES'($urandom_range(1, 14));
         else if (r < 8) m = '0;
         else            m = 4'hF;
         step(m, {$urandom, $urandom, $urandom, $urandom},
              $urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
